g3_vec_seq: RTL and testbench
=============================

G3_VEC_SEQ -- requirements
Module: g3_vec_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1, meaning the number of clock cycles each vector is held; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a request to begin a vector run, sampled only in IDLE.
REQ-005 SHALL have port mode, input, 1: 0 selects exhaustive (64 vectors), 1 selects directed (4 vectors); latched when start is accepted.
REQ-006 SHALL have ports a, b, c, d, e, f, each output, 1, forming the vector {a,b,c,d,e,f} fed to the downstream g3 stage (a = MSB).
REQ-007 SHALL have port valid, output, 1, high while a run vector is being driven.
REQ-008 SHALL have port busy, output, 1, high while a run is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking run completion.
REQ-010 SHALL have ports z1 and z2, each input, 1, carrying the g3 responses.
REQ-011 SHALL have port sig, output, 8, the response signature.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE and DONE.
REQ-013 IDLE: vector=0, valid=0, busy=0, done=0; if start=1, then on that edge go to DRIVE, set idx=0 and hold_cnt=0, and latch mode.
REQ-014 DRIVE: vector=table[idx], valid=1, busy=1; hold_cnt increments each cycle.
REQ-015 DRIVE exit: when hold_cnt==HOLD_CYCLES-1, hold_cnt returns to 0; if idx==last, go to DONE, else idx increments.
REQ-016 Exhaustive table: idx 0..63 maps vector=idx (6-bit). Directed table: 6'b000000, 6'b111111, 6'b010101, 6'b101010.
REQ-017 Latency: with start accepted at edge k, vector 0 is visible in cycle k+1; valid is high for exactly N*HOLD_CYCLES consecutive cycles, with no gaps.
REQ-018 DONE: done=1, valid=0, busy=0, vector=0 for exactly one cycle, then go to IDLE.
REQ-019 start in DRIVE or DONE SHALL be ignored and not queued; start in the first IDLE cycle after DONE SHALL be accepted.
REQ-020 A change on mode during a run SHALL have no effect.
REQ-021 idx SHALL never wrap: the run ends at idx 63 (exhaustive) or idx 3 (directed).

Reset
REQ-022 rst=1 SHALL force IDLE and clear idx, hold_cnt, vector, valid, busy, done and sig to 0 on the next edge, including when asserted mid-run.
REQ-023 rst SHALL take priority over start on the same edge.

Configuration
REQ-024 Macro G3_VEC_SEQ_SIG_EN SHALL control the signature register; when defined, sig is an 8-bit MISR.
REQ-025 MISR clear: sig is cleared to 0 when start is accepted.
REQ-026 MISR sampling: the MISR samples only in DRIVE cycles where hold_cnt==HOLD_CYCLES-1.
REQ-027 MISR update: sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ {6'b0, z1, z2}.
REQ-028 MISR hold: sig holds its value through DONE and IDLE until the next accepted start.
REQ-029 Without the macro, sig SHALL be constant 8'h00, z1 and z2 SHALL be unused, and no MISR logic SHALL exist.

Structure
REQ-030 A shared package g3_pkg SHALL hold the FSM state enum, the directed-vector constant table, the vector counts (64, 4) and the MISR tap constant.
REQ-031 The MISR SHALL be a sub-module named g3_misr, instantiated only under G3_VEC_SEQ_SIG_EN; all other logic stays in g3_vec_seq.

Verification
REQ-032 Reset: hold rst=1 for 2 cycles with start=1 -> all outputs 0 and the state is IDLE.
REQ-033 Directed run, HOLD_CYCLES=1: start pulse at cycle 0 -> cycles 1-4 show vectors 000000, 111111, 010101, 101010 with valid=busy=1; done=1 in cycle 5 only.
REQ-034 Exhaustive run, HOLD_CYCLES=2: start -> vectors 0..63, each for 2 cycles (128 valid cycles); done in cycle 129; no value repeats after 63.
REQ-035 Protocol: start held high for a whole run -> exactly one run, then a new run begins on the first IDLE cycle; mode toggled mid-run -> sequence unchanged.
REQ-036 Mid-run reset: rst at directed vector 2 -> next cycle vector=0, valid=busy=done=0, no done pulse follows.
REQ-037 With G3_VEC_SEQ_SIG_EN, directed run, HOLD_CYCLES=1: z2=1 on the first sample only -> sig=8'h08 at done; z1=z2=0 throughout -> sig=8'h00.

Source files
------------

// File: rtl/g3_pkg.sv
// Shared types and constants for the g3 vector sequencer: FSM states, vector
// tables and counts, and the MISR feedback taps.
package g3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } g3_state_e;

  localparam int unsigned EXH_COUNT = 64;
  localparam int unsigned DIR_COUNT = 4;

  localparam logic [5:0] EXH_LAST = 6'(EXH_COUNT - 1);
  localparam logic [5:0] DIR_LAST = 6'(DIR_COUNT - 1);

  // Entry 0 sits in the low slice, so DIRECTED_VEC[i] is directed vector i.
  localparam logic [3:0][5:0] DIRECTED_VEC = {6'b101010, 6'b010101, 6'b111111, 6'b000000};

  // Feedback taps sig[7], sig[5], sig[4], sig[3].
  localparam logic [7:0] MISR_TAPS = 8'b1011_1000;

  function automatic logic [5:0] vec_lookup(input logic dir_mode, input logic [5:0] idx);
    if (dir_mode) return DIRECTED_VEC[idx[1:0]];
    else return idx;
  endfunction

endpackage

// File: rtl/g3_misr.sv
// 8-bit signature register compacting the g3 responses z1/z2; only built when
// G3_VEC_SEQ_SIG_EN is defined.
module g3_misr
  import g3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       sample,
  input  logic       z1,
  input  logic       z2,
  output logic [7:0] sig
);

  logic fb;

  assign fb = ^(sig & MISR_TAPS);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sig <= 8'h00;
    end else if (sample) begin
      sig <= {sig[6:0], fb} ^ {6'b0, z1, z2};
    end
  end

endmodule

// File: rtl/g3_vec_seq.sv
// Vector sequencer for the g3 stage: drives exhaustive or directed vectors, each
// held HOLD_CYCLES cycles. Signature MISR is present only with G3_VEC_SEQ_SIG_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; outputs quiet
// ST_DRIVE | driving table[idx] for HOLD_CYCLES cycles per entry
// ST_DONE  | one-cycle done pulse, then back to idle
module g3_vec_seq
  import g3_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       valid,
  output logic       busy,
  output logic       done,
  input  logic       z1,
  input  logic       z2,
  output logic [7:0] sig
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  g3_state_e  state;
  g3_state_e  state_nxt;
  logic [5:0] idx;
  logic [3:0] hold_cnt;
  logic       mode_q;
  logic       start_acc;
  logic       hold_last;
  logic       idx_last;
  logic [5:0] vec;

  assign start_acc = (state == ST_IDLE) && start;
  assign hold_last = (hold_cnt == HOLD_LAST);
  assign idx_last  = (idx == (mode_q ? DIR_LAST : EXH_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_acc) state_nxt = ST_DRIVE;
      ST_DRIVE: if (hold_last && idx_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // idx stops on the last entry rather than wrapping; the FSM leaves DRIVE there.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 6'd0;
      hold_cnt <= 4'd0;
      mode_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            idx      <= 6'd0;
            hold_cnt <= 4'd0;
            mode_q   <= mode;
          end
        end
        ST_DRIVE: begin
          if (hold_last) begin
            hold_cnt <= 4'd0;
            if (!idx_last) idx <= idx + 6'd1;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: begin
          idx      <= 6'd0;
          hold_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    vec   = 6'd0;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_DRIVE: begin
        vec   = vec_lookup(mode_q, idx);
        valid = 1'b1;
        busy  = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign {a, b, c, d, e, f} = vec;

`ifdef G3_VEC_SEQ_SIG_EN
  logic sample;

  // One sample per vector, on the last cycle it is held.
  assign sample = (state == ST_DRIVE) && hold_last;

  g3_misr u_misr (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_acc),
    .sample (sample),
    .z1     (z1),
    .z2     (z2),
    .sig    (sig)
  );
`else
  logic unused_z;

  assign unused_z = z1 ^ z2;
  assign sig      = 8'h00;
`endif

endmodule

// File: tb/tb_g3_vec_seq.sv
// Scoreboard bench for g3_vec_seq: instance 0 holds each vector 1 cycle,
// instance 1 holds each vector 2 cycles.
module tb_g3_vec_seq;

  typedef struct packed {
    logic       is_done;
    logic [5:0] vec;
    logic [7:0] sig;
  } exp_t;

`ifdef G3_VEC_SEQ_SIG_EN
  localparam logic [7:0] EXP_Z2_FIRST = 8'h08;
`else
  localparam logic [7:0] EXP_Z2_FIRST = 8'h00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_s, start_s, mode_s, z1_s, z2_s;
  logic [1:0][5:0] vec_o;
  logic [1:0]      valid_o, busy_o, done_o;
  logic [1:0][7:0] sig_o;

  exp_t       sbq[2][$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] prev_sig[2];
  logic [5:0] dir_tab[4];
  bit         mon_en = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    exp_t ex;

    g3_vec_seq #(.HOLD_CYCLES(g == 0 ? 1 : 2)) dut (
      .clk   (clk),
      .rst   (rst_s[g]),
      .start (start_s[g]),
      .mode  (mode_s[g]),
      .a     (vec_o[g][5]),
      .b     (vec_o[g][4]),
      .c     (vec_o[g][3]),
      .d     (vec_o[g][2]),
      .e     (vec_o[g][1]),
      .f     (vec_o[g][0]),
      .valid (valid_o[g]),
      .busy  (busy_o[g]),
      .done  (done_o[g]),
      .z1    (z1_s[g]),
      .z2    (z2_s[g]),
      .sig   (sig_o[g])
    );

    always @(negedge clk) begin
      if (mon_en) begin
        if (valid_o[g] || done_o[g]) begin
          n_checks++;
          if (sbq[g].size() == 0) begin
            n_fail++;
            $display("FAIL mon%0d_unexpected: got valid=%b done=%b vec=%b, required no output",
                     g, valid_o[g], done_o[g], vec_o[g]);
          end else begin
            ex = sbq[g].pop_front();
            if (ex.is_done !== done_o[g] || ex.is_done === valid_o[g]) begin
              n_fail++;
              $display("FAIL mon%0d_kind: got valid=%b done=%b, required done=%b",
                       g, valid_o[g], done_o[g], ex.is_done);
            end else if (!ex.is_done && vec_o[g] !== ex.vec) begin
              n_fail++;
              $display("FAIL mon%0d_vec: got %b, required %b", g, vec_o[g], ex.vec);
            end else if (ex.is_done && (sig_o[g] !== ex.sig || vec_o[g] !== 6'd0)) begin
              n_fail++;
              $display("FAIL mon%0d_done: got sig=%h vec=%b, required sig=%h vec=000000",
                       g, sig_o[g], vec_o[g], ex.sig);
            end
          end
        end
        n_checks++;
        if (busy_o[g] !== valid_o[g] || (!valid_o[g] && vec_o[g] !== 6'd0)) begin
          n_fail++;
          $display("FAIL mon%0d_proto: got busy=%b valid=%b vec=%b, required busy=valid and vec=0 when not valid",
                   g, busy_o[g], valid_o[g], vec_o[g]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] misr_model(input logic [7:0] s, input logic z1, input logic z2);
`ifdef G3_VEC_SEQ_SIG_EN
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb} ^ {6'b0, z1, z2};
`else
    return 8'h00 & {s[7:2], z1, z2};
`endif
  endfunction

  // zmode: 0 random z, 1 z2 only on the first vector, 2 all zero.
  task automatic run(input int u, input bit m, input int zmode, input bit hold_start,
                     input bit toggle_mode);
    int         n, h;
    logic [7:0] s;
    exp_t       ex;
    n = m ? 4 : 64;
    h = (u == 0) ? 1 : 2;
    s = 8'h00;
    @(posedge clk); #1;
    chk("idle_busy", busy_o[u], 0);
    chk("idle_sig_hold", sig_o[u], prev_sig[u]);
    start_s[u] = 1'b1;
    mode_s[u]  = m;
    for (int j = 0; j < n; j++) begin
      for (int r = 0; r < h; r++) begin
        ex.is_done = 1'b0;
        ex.vec     = m ? dir_tab[j] : 6'(j);
        ex.sig     = 8'h00;
        sbq[u].push_back(ex);
      end
    end
    for (int j = 0; j < n; j++) begin
      for (int r = 0; r < h; r++) begin
        @(posedge clk); #1;
        start_s[u] = hold_start | 1'($urandom_range(0, 1));
        if (toggle_mode) mode_s[u] = 1'($urandom_range(0, 1));
        case (zmode)
          0: begin z1_s[u] = 1'($urandom_range(0, 1)); z2_s[u] = 1'($urandom_range(0, 1)); end
          1: begin z1_s[u] = 1'b0; z2_s[u] = (j == 0); end
          default: begin z1_s[u] = 1'b0; z2_s[u] = 1'b0; end
        endcase
        if (r == h - 1) s = misr_model(s, z1_s[u], z2_s[u]);
      end
    end
    ex.is_done = 1'b1;
    ex.vec     = 6'd0;
    ex.sig     = s;
    sbq[u].push_back(ex);
    @(posedge clk); #1;
    chk("done_latency", done_o[u], 1);
    start_s[u] = hold_start;
    z1_s[u]    = 1'($urandom_range(0, 1));
    z2_s[u]    = 1'($urandom_range(0, 1));
    prev_sig[u] = s;
  endtask

  task automatic midrun_reset();
    exp_t ex;
    @(posedge clk); #1;
    chk("mr_idle_busy", busy_o[0], 0);
    start_s[0] = 1'b1;
    mode_s[0]  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ex.is_done = 1'b0;
      ex.vec     = dir_tab[j];
      ex.sig     = 8'h00;
      sbq[0].push_back(ex);
    end
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      z1_s[0] = 1'b1;
      z2_s[0] = 1'b1;
    end
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    chk("mr_vec", vec_o[0], 0);
    chk("mr_valid", valid_o[0], 0);
    chk("mr_busy", busy_o[0], 0);
    chk("mr_done", done_o[0], 0);
    chk("mr_sig", sig_o[0], 0);
    rst_s[0] = 1'b0;
    prev_sig[0] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mr_no_done", done_o[0], 0);
    end
  endtask

  initial begin
    dir_tab[0] = 6'b000000;
    dir_tab[1] = 6'b111111;
    dir_tab[2] = 6'b010101;
    dir_tab[3] = 6'b101010;
    prev_sig[0] = 8'h00;
    prev_sig[1] = 8'h00;
    rst_s   = 2'b11;
    start_s = 2'b11;
    mode_s  = 2'b01;
    z1_s    = 2'b11;
    z2_s    = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_vec", vec_o[u], 0);
      chk("rst_valid", valid_o[u], 0);
      chk("rst_busy", busy_o[u], 0);
      chk("rst_done", done_o[u], 0);
      chk("rst_sig", sig_o[u], 0);
    end
    rst_s   = 2'b00;
    start_s = 2'b00;
    z1_s    = 2'b00;
    z2_s    = 2'b00;
    mon_en  = 1'b1;
    @(posedge clk); #1;
    chk("rst_stays_idle", busy_o, 0);

    run(0, 1'b1, 1, 1'b0, 1'b0);
    chk("sig_z2_first", sig_o[0], EXP_Z2_FIRST);
    run(0, 1'b1, 2, 1'b0, 1'b0);
    chk("sig_all_zero", sig_o[0], 8'h00);
    run(0, 1'b1, 0, 1'b1, 1'b1);
    run(0, 1'b0, 0, 1'b1, 1'b1);
    run(0, 1'b1, 0, 1'b0, 1'b0);
    run(1, 1'b0, 0, 1'b0, 1'b0);
    run(1, 1'b1, 0, 1'b1, 1'b1);
    run(1, 1'b0, 0, 1'b0, 1'b1);
    midrun_reset();
    for (int i = 0; i < 4; i++) begin
      run(i % 2, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1'b1);
      start_s = 2'b00;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("sbq0_drained", sbq[0].size(), 0);
    chk("sbq1_drained", sbq[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
